// File: rtl/pit_multi.sv
// pit_multi: multi-channel programmable interval timer with byte-wide register access
module pit_multi #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [AW-1:0]     addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  input  logic [NUM_CH-1:0] gate,
  output logic [NUM_CH-1:0] out,
  output logic              irq
);
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] TWO = {{(CNT_W-1){1'b0}}, 2'd2};
  localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};
  logic [AW-1:0] ch;
  logic [1:0] rsel;
  logic [7:0] rd_val [NUM_CH];
  logic [NUM_CH-1:0] irq_d;
  logic [7:0] rdata_d;
  assign ch = addr >> 2;
  assign rsel = addr[1:0];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0] ctrl_q, ctrl_d;
    logic [7:0] lo_q, lo_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W:0] cnt_q, cnt_d, ne;
    logic [15:0] latch_q, latch_d;
    logic lp_q, lp_d, run_q, run_d, out_q, out_d, tc_q, tc_d, gate_q, tc_set, hit, clr;
    assign hit = cs && ch == AW'(c);
    assign clr = hit && rsel == 2'd3 && (rd || (wr && wdata[1]));
    assign ne = n_q == '0 ? FULL : (ctrl_q[1] && n_q == CNT_W'(1)) ? TWO : {1'b0, n_q};
    assign rd_val[c] = rsel == 2'd0 ? 8'(cnt_q) : rsel == 2'd1 ? latch_q[15:8] :
                       rsel == 2'd2 ? {4'b0, ctrl_q} : {6'b0, tc_q, out_q};
    assign out[c] = out_q;
    assign irq_d[c] = tc_d && ctrl_d[3];
    // next channel state: tick-driven counting first, then gate edge, then register writes override
    always_comb begin
      ctrl_d = ctrl_q;
      lo_d = lo_q;
      n_d = n_q;
      cnt_d = cnt_q;
      latch_d = latch_q;
      lp_d = lp_q;
      run_d = run_q;
      out_d = out_q;
      tc_set = 1'b0;
      if (tick && ctrl_q[2]) begin
        if (lp_q) begin
          cnt_d = ne;
          lp_d = 1'b0;
          run_d = 1'b1;
          out_d = ctrl_q[1];
        end else if (run_q && !ctrl_q[1]) begin
          if (gate[c] && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
            tc_set = cnt_q == ONE;
            out_d = out_q || tc_set;
          end
        end else if (run_q && !gate[c]) begin
          out_d = 1'b1;
        end else if (run_q) begin
          tc_set = cnt_q == ONE;
          cnt_d = tc_set ? ne : cnt_q - ONE;
          out_d = ctrl_q[0] ? cnt_d > (ne >> 1) : cnt_d != ONE;
        end
      end
      if (ctrl_q[2] && ctrl_q[1] && run_q && gate[c] && !gate_q) lp_d = 1'b1;
      if (hit && rd && rsel == 2'd0) latch_d = 16'(cnt_q);
      if (hit && wr && rsel == 2'd0) lo_d = wdata;
      if (hit && wr && rsel == 2'd1) begin
        n_d = CNT_W'({wdata, lo_q});
        lp_d = 1'b1;
      end
      if (hit && wr && rsel == 2'd2) begin
        ctrl_d = wdata[3:0];
        run_d = 1'b0;
        lp_d = 1'b0;
        out_d = wdata[1];
      end
      tc_d = (tc_q && !clr) || tc_set;
    end
    // channel state registers
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ctrl_q <= '0;
        lo_q <= '0;
        n_q <= '0;
        cnt_q <= '0;
        latch_q <= '0;
        lp_q <= 1'b0;
        run_q <= 1'b0;
        out_q <= 1'b0;
        tc_q <= 1'b0;
        gate_q <= 1'b0;
      end else begin
        ctrl_q <= ctrl_d;
        lo_q <= lo_d;
        n_q <= n_d;
        cnt_q <= cnt_d;
        latch_q <= latch_d;
        lp_q <= lp_d;
        run_q <= run_d;
        out_q <= out_d;
        tc_q <= tc_d;
        gate_q <= gate[c];
      end
  end
  // read mux; unimplemented channels return zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) if (ch == AW'(i)) rdata_d = rd_val[i];
  end
  // registered read data and interrupt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata <= '0;
      irq <= 1'b0;
    end else begin
      if (cs && rd) rdata <= rdata_d;
      irq <= |irq_d;
    end
endmodule
